// File: rtl/rr_reduction_arbiter.sv
// Registered round-robin arbiter over NUM_CH reduction input FIFOs.
// Presents one granted channel index per valid/ready handshake and pops the granted FIFO on accept.
module rr_reduction_arbiter #(
  parameter int NUM_CH    = 7,
  parameter int IDX_W     = 3,
  parameter int BURST_MAX = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] req_more,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [NUM_CH-1:0] pop,
  output logic [IDX_W-1:0]  last_idx,
  output logic [IDX_W:0]    burst_cnt
);

  localparam logic [IDX_W-1:0] NONE = IDX_W'(NUM_CH);
  localparam logic [IDX_W:0]   BMAX = (IDX_W+1)'(BURST_MAX);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W:0]     burst_q;

  logic               accept;
  logic [NUM_CH-1:0]  eff;
  logic [IDX_W-1:0]   ptr_d;
  logic [IDX_W:0]     burst_d;
  logic [IDX_W:0]     cnt_sel;
  logic [IDX_W-1:0]   srch_idx;
  logic [IDX_W-1:0]   sel_d;
  logic               found;
  int unsigned        cand;

  assign out_valid = (state_q == S_GRANT);
  assign out_idx   = out_idx_q;
  assign last_idx  = last_q;
  assign burst_cnt = burst_q;

  assign accept = out_valid & out_ready & ~clr;
  assign pop    = accept ? (NUM_CH'(1) << out_idx_q) : '0;
  assign eff    = req & ~(pop & ~req_more);

  always_comb begin
    burst_d = 1'b1;
    if (out_idx_q == last_q)
      burst_d = (burst_q >= BMAX) ? BMAX : burst_q + 1'b1;
  end

  // An accept this cycle moves the pointer, so the next selection already
  // searches from the channel just popped; this is what allows one grant per cycle.
  assign ptr_d   = accept ? out_idx_q : last_q;
  assign cnt_sel = accept ? burst_d : burst_q;

  always_comb begin
    found    = 1'b0;
    srch_idx = NONE;
    cand     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ptr_d == NONE)
        cand = i;
      else
        cand = (32'(ptr_d) + 1 + i) % NUM_CH;
      if (!found && |(eff & (NUM_CH'(1) << cand))) begin
        found    = 1'b1;
        srch_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    sel_d = srch_idx;
    if (BURST_MAX > 1 && ptr_d != NONE && cnt_sel < BMAX
        && |(eff & (NUM_CH'(1) << ptr_d)))
      sel_d = ptr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      out_idx_q <= NONE;
      last_q    <= NONE;
      burst_q   <= '0;
    end else if (clr) begin
      state_q   <= S_IDLE;
      out_idx_q <= NONE;
      last_q    <= NONE;
      burst_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_idx_q <= sel_d;
          state_q   <= (sel_d == NONE) ? S_IDLE : S_GRANT;
        end
        S_GRANT: begin
          if (out_ready) begin
            last_q    <= out_idx_q;
            burst_q   <= burst_d;
            out_idx_q <= sel_d;
            state_q   <= (sel_d == NONE) ? S_IDLE : S_GRANT;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          out_idx_q <= NONE;
        end
      endcase
    end
  end

endmodule
